// File: rtl/gpu_axi_traffic_gen.sv
// AXI3 INCR-burst traffic master: writes address-tagged data, optionally reads it back,
// and counts response, ID, data and rlast errors in a saturating counter.
module gpu_axi_traffic_gen #(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 64,
    parameter int          ID_W   = 8,
    parameter int unsigned ID_VAL = 0,
    parameter int          OSTD   = 4,
    parameter int          CNT_W  = 16
) (
    input  logic                  acr_clk,
    input  logic                  acr_rst,
    input  logic                  cfg_start,
    input  logic [1:0]            cfg_mode,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [CNT_W-1:0]      cfg_num_bursts,
    input  logic [3:0]            cfg_len,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [2:0]            dbg_state,
    output logic [ID_W-1:0]       axi_awid,
    output logic [ADDR_W-1:0]     axi_awaddr,
    output logic [3:0]            axi_awlen,
    output logic [2:0]            axi_awsize,
    output logic [1:0]            axi_awburst,
    output logic                  axi_awlock,
    output logic [3:0]            axi_awcache,
    output logic [2:0]            axi_awprot,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [DATA_W-1:0]     axi_wdata,
    output logic [DATA_W/8-1:0]   axi_wstrb,
    output logic                  axi_wlast,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [ID_W-1:0]       axi_bid,
    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    output logic [ID_W-1:0]       axi_arid,
    output logic [ADDR_W-1:0]     axi_araddr,
    output logic [3:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    output logic                  axi_arlock,
    output logic [3:0]            axi_arcache,
    output logic [2:0]            axi_arprot,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [ID_W-1:0]       axi_rid,
    input  logic [DATA_W-1:0]     axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);
    localparam logic [2:0]        SIZE   = 3'($clog2(DATA_W/8));
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(DATA_W/8);
    localparam logic [ID_W-1:0]   ID_C   = ID_W'(ID_VAL);
    localparam logic [3:0]        OSTD_C = 4'(OSTD);

    typedef enum logic [2:0] {IDLE = 3'd0, WR = 3'd1, WDRAIN = 3'd2, RD = 3'd3, DONE = 3'd4} state_t;
    state_t state_q, state_d;

    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  num_q, wr_burst_q, ar_cnt_q, err_q, err_d;
    logic [3:0]        len_q, wbeat_q, rbeat_q, pend_b_q, rd_ost_q;
    logic              w_phase_q;
    logic [ADDR_W-1:0] wr_addr_q, ar_addr_q, rd_addr_q, burst_bytes;
    logic [1:0]        err_inc;
    logic [CNT_W:0]    err_sum;
    logic              start_acc, aw_hs, w_hs, w_last_hs, b_hs, ar_hs, r_hs, r_last_hs, r_exp_last;
    logic [DATA_W-1:0] exp_data;

    // Every valid is a function of registered state only, so it cannot drop before its handshake.
    assign axi_awvalid = (state_q == WR) && !w_phase_q && (pend_b_q != OSTD_C);
    assign axi_wvalid  = (state_q == WR) && w_phase_q;
    assign axi_bready  = (state_q == WR) || (state_q == WDRAIN);
    assign axi_arvalid = (state_q == RD) && (ar_cnt_q != num_q) && (rd_ost_q != OSTD_C);
    assign axi_rready  = (state_q == RD);

    assign start_acc  = (state_q == IDLE) && cfg_start;
    assign aw_hs      = axi_awvalid && axi_awready;
    assign w_hs       = axi_wvalid && axi_wready;
    assign w_last_hs  = w_hs && axi_wlast;
    assign b_hs       = axi_bvalid && axi_bready;
    assign ar_hs      = axi_arvalid && axi_arready;
    assign r_hs       = axi_rvalid && axi_rready;
    assign r_last_hs  = r_hs && axi_rlast;
    assign r_exp_last = (rbeat_q == len_q);
    assign exp_data   = DATA_W'(rd_addr_q);
    assign burst_bytes = (ADDR_W'(len_q) + ADDR_W'(1)) * STEP;

    assign axi_awid    = ID_C;
    assign axi_awaddr  = wr_addr_q;
    assign axi_awlen   = len_q;
    assign axi_awsize  = SIZE;
    assign axi_awburst = 2'b01;
    assign axi_awlock  = 1'b0;
    assign axi_awcache = 4'b0011;
    assign axi_awprot  = 3'b000;
    assign axi_wdata   = DATA_W'(wr_addr_q);
    assign axi_wstrb   = '1;
    assign axi_wlast   = (wbeat_q == len_q);
    assign axi_arid    = ID_C;
    assign axi_araddr  = ar_addr_q;
    assign axi_arlen   = len_q;
    assign axi_arsize  = SIZE;
    assign axi_arburst = 2'b01;
    assign axi_arlock  = 1'b0;
    assign axi_arcache = 4'b0011;
    assign axi_arprot  = 3'b000;

    assign busy      = (state_q == WR) || (state_q == WDRAIN) || (state_q == RD);
    assign done      = (state_q == DONE);
    assign err_cnt   = err_q;
    assign dbg_state = state_q;

    always_ff @(posedge acr_clk) begin
        if (acr_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_num_bursts == '0)  state_d = DONE;
                    else if (cfg_mode == 2'd1) state_d = RD;
                    else                       state_d = WR;
                end
            end
            WR:      if (w_last_hs && (wr_burst_q == num_q - CNT_W'(1))) state_d = WDRAIN;
            WDRAIN:  if (pend_b_q == '0) state_d = mode_q[1] ? RD : DONE;
            RD:      if ((ar_cnt_q == num_q) && (rd_ost_q == '0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A read beat scores at most one data/resp/id error plus one rlast-position error.
    always_comb begin
        err_inc = 2'd0;
        if (b_hs && ((axi_bresp != 2'b00) || (axi_bid != ID_C))) err_inc = 2'd1;
        if (r_hs) begin
            if (((mode_q != 2'd1) && (axi_rdata != exp_data)) || (axi_rresp != 2'b00) || (axi_rid != ID_C))
                err_inc = err_inc + 2'd1;
            if (axi_rlast != r_exp_last) err_inc = err_inc + 2'd1;
        end
        err_sum = {1'b0, err_q} + {{(CNT_W-1){1'b0}}, err_inc};
        err_d   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end

    always_ff @(posedge acr_clk) begin
        if (acr_rst) begin
            mode_q <= '0; num_q <= '0; len_q <= '0; w_phase_q <= 1'b0; wbeat_q <= '0;
            wr_burst_q <= '0; pend_b_q <= '0; ar_cnt_q <= '0; rd_ost_q <= '0; rbeat_q <= '0;
            wr_addr_q <= '0; ar_addr_q <= '0; rd_addr_q <= '0; err_q <= '0;
        end else if (start_acc) begin
            mode_q <= cfg_mode; num_q <= cfg_num_bursts; len_q <= cfg_len; w_phase_q <= 1'b0;
            wbeat_q <= '0; wr_burst_q <= '0; pend_b_q <= '0; ar_cnt_q <= '0; rd_ost_q <= '0;
            rbeat_q <= '0; wr_addr_q <= cfg_base; ar_addr_q <= cfg_base; rd_addr_q <= cfg_base;
            err_q <= '0;
        end else begin
            if (aw_hs) w_phase_q <= 1'b1;
            if (w_hs) begin
                wr_addr_q <= wr_addr_q + STEP;
                wbeat_q   <= axi_wlast ? 4'd0 : wbeat_q + 4'd1;
            end
            if (w_last_hs) begin
                w_phase_q  <= 1'b0;
                wr_burst_q <= wr_burst_q + CNT_W'(1);
            end
            pend_b_q <= pend_b_q + 4'(w_last_hs) - 4'(b_hs);
            if (ar_hs) begin
                ar_addr_q <= ar_addr_q + burst_bytes;
                ar_cnt_q  <= ar_cnt_q + CNT_W'(1);
            end
            rd_ost_q <= rd_ost_q + 4'(ar_hs) - 4'(r_last_hs);
            if (r_hs) begin
                rd_addr_q <= rd_addr_q + STEP;
                rbeat_q   <= r_exp_last ? 4'd0 : rbeat_q + 4'd1;
            end
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_gpu_axi_traffic_gen.sv
// Directed bench for gpu_axi_traffic_gen with a negedge-driven AXI slave memory model.
module tb_gpu_axi_traffic_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cfg_start = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [31:0] cfg_base = '0;
    logic [15:0] cfg_num_bursts = '0;
    logic [3:0]  cfg_len = '0;
    logic        busy, done;
    logic [15:0] err_cnt;
    logic [2:0]  dbg_state;
    logic [7:0]  axi_awid, axi_arid;
    logic [31:0] axi_awaddr, axi_araddr;
    logic [3:0]  axi_awlen, axi_arlen, axi_awcache, axi_arcache;
    logic [2:0]  axi_awsize, axi_arsize, axi_awprot, axi_arprot;
    logic [1:0]  axi_awburst, axi_arburst;
    logic        axi_awlock, axi_arlock, axi_awvalid, axi_wvalid, axi_wlast, axi_bready;
    logic        axi_arvalid, axi_rready;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_awready = 1'b0, axi_wready = 1'b0, axi_arready = 1'b0;
    logic        axi_bvalid = 1'b0, axi_rvalid = 1'b0, axi_rlast = 1'b0;
    logic [7:0]  axi_bid = '0, axi_rid = '0;
    logic [1:0]  axi_bresp = '0, axi_rresp = '0;
    logic [63:0] axi_rdata = '0;

    gpu_axi_traffic_gen dut (
        .acr_clk(clk), .acr_rst(rst), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
        .cfg_base(cfg_base), .cfg_num_bursts(cfg_num_bursts), .cfg_len(cfg_len),
        .busy(busy), .done(done), .err_cnt(err_cnt), .dbg_state(dbg_state),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Slave model state. Handshakes are decided at the negedge (all DUT valids/readies are
    // register-driven) and their side effects applied at the following negedge.
    logic [63:0] mem [logic [31:0]];
    logic [31:0] aw_log[$], ar_log[$], aw_pend[$], ar_pend[$];
    logic [3:0]  ar_pend_len[$];
    logic [63:0] w_log[$];
    bit          wl_log[$];
    logic [1:0]  b_pend[$];
    logic [31:0] s_addr;
    int  w_beat = 0, r_beat = 0, b_total = 0, r_total = 0, rd_out = 0, wb_out = 0, viol = 0;
    int  bad_b_idx = -1, flip_r_idx = -1, bad_rresp_idx = -1;
    bit  stall = 1'b0;
    bit  b_hs_f, r_hs_f, aw_hs_f, w_last_f, ar_hs_f, w_hs_f;
    bit  prev_aw, prev_w, prev_ar;

    function automatic bit rnd_ok();
        return !stall || ($urandom_range(0, 3) != 0);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            aw_pend.delete(); ar_pend.delete(); ar_pend_len.delete(); b_pend.delete();
            w_beat = 0; r_beat = 0; rd_out = 0; wb_out = 0;
            b_hs_f = 0; r_hs_f = 0; aw_hs_f = 0; w_hs_f = 0; w_last_f = 0; ar_hs_f = 0;
            prev_aw = 0; prev_w = 0; prev_ar = 0;
            axi_awready = 0; axi_wready = 0; axi_arready = 0; axi_bvalid = 0; axi_rvalid = 0;
            axi_rlast = 0;
        end else begin
            if (w_last_f) wb_out++;
            if (ar_hs_f) rd_out++;
            if (b_hs_f) begin
                void'(b_pend.pop_front());
                wb_out--;
                axi_bvalid = 0;
            end
            if (r_hs_f) begin
                r_total++;
                if (axi_rlast) begin
                    rd_out--; r_beat = 0;
                    void'(ar_pend.pop_front()); void'(ar_pend_len.pop_front());
                end else r_beat++;
                axi_rvalid = 0;
            end
            if (prev_aw && !aw_hs_f && !axi_awvalid) viol++;
            if (prev_w && !w_hs_f && !axi_wvalid) viol++;
            if (prev_ar && !ar_hs_f && !axi_arvalid) viol++;
            if (axi_awvalid && wb_out >= 4) viol++;
            if (axi_arvalid && rd_out >= 4) viol++;
            if (!axi_bvalid && b_pend.size() > 0 && rnd_ok()) begin
                axi_bvalid = 1; axi_bresp = b_pend[0]; axi_bid = 8'h00;
            end
            b_hs_f = axi_bvalid && axi_bready;
            if (!axi_rvalid && ar_pend.size() > 0 && rnd_ok()) begin
                s_addr = ar_pend[0] + 32'(r_beat) * 32'd8;
                axi_rdata = mem.exists(s_addr) ? mem[s_addr] : 64'(s_addr);
                if (r_total == flip_r_idx) axi_rdata = axi_rdata ^ 64'h1;
                axi_rresp = (r_total == bad_rresp_idx) ? 2'b10 : 2'b00;
                axi_rlast = (4'(r_beat) == ar_pend_len[0]);
                axi_rid = 8'h00; axi_rvalid = 1;
            end
            r_hs_f = axi_rvalid && axi_rready;
            axi_awready = rnd_ok(); axi_wready = rnd_ok(); axi_arready = rnd_ok();
            aw_hs_f = axi_awvalid && axi_awready;
            if (aw_hs_f) begin
                aw_log.push_back(axi_awaddr); aw_pend.push_back(axi_awaddr);
            end
            w_hs_f = axi_wvalid && axi_wready;
            w_last_f = w_hs_f && axi_wlast;
            if (w_hs_f) begin
                if (aw_pend.size() == 0) viol++;
                s_addr = (aw_pend.size() > 0 ? aw_pend[0] : 32'd0) + 32'(w_beat) * 32'd8;
                mem[s_addr] = axi_wdata;
                w_log.push_back(axi_wdata); wl_log.push_back(axi_wlast);
                if (axi_wlast) begin
                    b_pend.push_back((b_total == bad_b_idx) ? 2'b10 : 2'b00);
                    b_total++; w_beat = 0;
                    if (aw_pend.size() > 0) void'(aw_pend.pop_front());
                end else w_beat++;
            end
            ar_hs_f = axi_arvalid && axi_arready;
            if (ar_hs_f) begin
                ar_log.push_back(axi_araddr); ar_pend.push_back(axi_araddr);
                ar_pend_len.push_back(axi_arlen);
            end
            prev_aw = axi_awvalid; prev_w = axi_wvalid; prev_ar = axi_arvalid;
        end
    end

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_busy_in_done"}, busy, 0);
        step();
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    task automatic start(input logic [1:0] m, input logic [31:0] b, input logic [15:0] nb,
                         input logic [3:0] l);
        cfg_mode = m; cfg_base = b; cfg_num_bursts = nb; cfg_len = l; cfg_start = 1;
        step();
        cfg_start = 0;
    endtask

    initial begin
        int aw0, w0, ar0, r0, v0, n;
        repeat (3) step();
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_wvalid", axi_wvalid, 0);
        check("rst_arvalid", axi_arvalid, 0);
        check("rst_bready", axi_bready, 0);
        check("rst_rready", axi_rready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_cnt, 0);
        check("rst_state", dbg_state, 0);
        rst = 0;
        step();

        // Write-only, always-ready slave.
        aw0 = aw_log.size(); w0 = w_log.size(); ar0 = ar_log.size(); v0 = viol;
        start(2'd0, 32'h1000, 16'd3, 4'd3);
        check("t1_busy", busy, 1);
        check("t1_state_wr", dbg_state, 1);
        check("t1_awvalid_first", axi_awvalid, 1);
        check("t1_awaddr0", axi_awaddr, 32'h1000);
        check("t1_awlen", axi_awlen, 3);
        check("t1_awsize", axi_awsize, 3);
        check("t1_awburst", axi_awburst, 1);
        check("t1_awcache", axi_awcache, 4'b0011);
        check("t1_awlock", axi_awlock, 0);
        check("t1_awprot", axi_awprot, 0);
        check("t1_awid", axi_awid, 0);
        check("t1_wstrb", axi_wstrb, 8'hff);
        start(2'd1, 32'h0, 16'd0, 4'd0);
        check("t1_start_while_busy_ignored", busy, 1);
        wait_done("t1", 200);
        check("t1_aw_count", aw_log.size() - aw0, 3);
        for (int k = 0; k < 3; k++) check("t1_awaddr", aw_log[aw0 + k], 32'h1000 + 32'(k) * 32'h20);
        check("t1_w_count", w_log.size() - w0, 12);
        for (int i = 0; i < 12; i++) begin
            check("t1_wdata", w_log[w0 + i], 64'h1000 + 64'(i) * 64'd8);
            check("t1_wlast", wl_log[w0 + i], (i % 4) == 3);
        end
        check("t1_no_reads", ar_log.size() - ar0, 0);
        check("t1_err", err_cnt, 0);
        check("t1_protocol", viol - v0, 0);

        // Write then read-check with random stalls on every channel.
        aw0 = aw_log.size(); ar0 = ar_log.size(); r0 = r_total; v0 = viol;
        stall = 1;
        start(2'd2, 32'h2000_0000, 16'd8, 4'd15);
        wait_done("t2", 20000);
        stall = 0;
        check("t2_err", err_cnt, 0);
        check("t2_aw_count", aw_log.size() - aw0, 8);
        check("t2_ar_count", ar_log.size() - ar0, 8);
        check("t2_ar_first", ar_log[ar0], 32'h2000_0000);
        check("t2_ar_last", ar_log[ar0 + 7], 32'h2000_0380);
        check("t2_r_beats", r_total - r0, 128);
        check("t2_protocol_ostd", viol - v0, 0);

        // Read-only: a corrupted beat is not counted, an SLVERR beat is.
        aw0 = aw_log.size(); r0 = r_total;
        flip_r_idx = r_total + 1; bad_rresp_idx = r_total + 5;
        start(2'd1, 32'h4000, 16'd2, 4'd3);
        check("t3_state_rd", dbg_state, 3);
        check("t3_arvalid", axi_arvalid, 1);
        check("t3_araddr", axi_araddr, 32'h4000);
        check("t3_arlen", axi_arlen, 3);
        check("t3_arsize", axi_arsize, 3);
        check("t3_arburst", axi_arburst, 1);
        check("t3_arcache", axi_arcache, 4'b0011);
        check("t3_arlock_prot_id", {axi_arlock, axi_arprot, axi_arid}, 0);
        check("t3_no_aw", axi_awvalid, 0);
        wait_done("t3", 500);
        check("t3_err", err_cnt, 1);
        check("t3_no_writes", aw_log.size() - aw0, 0);
        check("t3_r_beats", r_total - r0, 8);
        flip_r_idx = -1; bad_rresp_idx = -1;

        // Write-read: bad bresp on burst 1, flipped data bit on burst 2 beat 0.
        bad_b_idx = b_total + 1; flip_r_idx = r_total + 4;
        start(2'd3, 32'h8000, 16'd3, 4'd1);
        wait_done("t4", 500);
        check("t4_err", err_cnt, 2);
        bad_b_idx = -1; flip_r_idx = -1;

        // Zero bursts: straight to DONE, no traffic.
        aw0 = aw_log.size(); ar0 = ar_log.size();
        start(2'd2, 32'h9000, 16'd0, 4'd3);
        check("t5_done", done, 1);
        check("t5_busy", busy, 0);
        check("t5_valids", {axi_awvalid, axi_wvalid, axi_arvalid}, 0);
        check("t5_err_cleared", err_cnt, 0);
        step();
        check("t5_done_one_cycle", done, 0);
        check("t5_no_traffic", (aw_log.size() - aw0) + (ar_log.size() - ar0), 0);

        // Reset in the middle of a write burst, then a clean run.
        bad_b_idx = b_total;
        start(2'd0, 32'h100, 16'd4, 4'd7);
        n = 0;
        while (!(err_cnt == 16'd1 && axi_wvalid) && n < 500) begin
            step();
            n++;
        end
        check("t6_pre_err", err_cnt, 1);
        check("t6_pre_wvalid", axi_wvalid, 1);
        rst = 1;
        step();
        check("t6_rst_valids", {axi_awvalid, axi_wvalid, axi_arvalid}, 0);
        check("t6_rst_readies", {axi_bready, axi_rready}, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_err", err_cnt, 0);
        rst = 0;
        bad_b_idx = -1;
        step();
        aw0 = aw_log.size(); w0 = w_log.size(); ar0 = ar_log.size();
        start(2'd2, 32'h3000, 16'd2, 4'd2);
        wait_done("t6", 500);
        check("t6_err", err_cnt, 0);
        check("t6_aw_count", aw_log.size() - aw0, 2);
        check("t6_awaddr1", aw_log[aw0 + 1], 32'h3018);
        check("t6_w_count", w_log.size() - w0, 6);
        check("t6_ar_count", ar_log.size() - ar0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end within the time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
